// File: rtl/wb_arb2.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb2
// Description : Two-master round-robin Wishbone arbiter with cyc-long grant
//               lock and a per-strobe watchdog that terminates stalls with err.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arb2 #(
    parameter int AW      = 24,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic              clk,
    input  logic              rstn,
    // master 0
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic [DW-1:0]     m0_dat_o,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic              m0_we_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    // master 1
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic [DW-1:0]     m1_dat_o,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic              m1_we_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    // slave
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic [DW-1:0]     s_dat_i,
    output logic [DW/8-1:0]   s_sel_o,
    output logic              s_we_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    input  logic              s_ack_i,
    output logic [1:0]        gnt_o
);

    localparam logic [CW-1:0] c_timeout  = CW'(TIMEOUT);
    localparam logic          c_wdog_en  = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last;
    logic            w_last_nxt;
    logic [CW-1:0]   r_wdog;
    logic [CW-1:0]   w_wdog_nxt;

    logic            w_own0;
    logic            w_own1;
    logic            w_cyc_sel;
    logic            w_stb_sel;
    logic            w_timeout;

    assign w_own0    = (r_state == ST_OWN0);
    assign w_own1    = (r_state == ST_OWN1);
    assign w_cyc_sel = (w_own0 & m0_cyc_i) | (w_own1 & m1_cyc_i);
    assign w_stb_sel = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);

    // Ack on the deadline cycle wins over the timeout.
    assign w_timeout = c_wdog_en & w_stb_sel & ~s_ack_i & (r_wdog == c_timeout);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
                else if (m0_cyc_i)
                    w_state_nxt = ST_OWN0;
                else if (m1_cyc_i)
                    w_state_nxt = ST_OWN1;
            end
            ST_OWN0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = 1'b0;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter is zero in IDLE, so every entry to an owner state starts at 0.
    always_comb begin
        w_wdog_nxt = '0;
        if (c_wdog_en && w_cyc_sel && w_stb_sel && !s_ack_i && !w_timeout)
            w_wdog_nxt = (r_wdog == c_timeout) ? r_wdog : r_wdog + 1'b1;
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        gnt_o    = 2'b00;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        if (w_own0) begin
            gnt_o    = 2'b01;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i & ~w_timeout;
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = w_timeout;
        end else if (w_own1) begin
            gnt_o    = 2'b10;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i & ~w_timeout;
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = w_timeout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arb2
// Description : Directed self-checking bench for wb_arb2 (TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arb2;

    localparam int AW = 24;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rstn;
    logic [AW-1:0]   m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [DW/8-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic            m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic            m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic            s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [1:0]      gnt_o;

    // {gnt[1:0], s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err}
    logic [7:0]      st;
    assign st = {gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(8), .CW(8)) dut (
        .clk(clk), .rstn(rstn),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i  = '0; s_ack_i  = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 24'hABCDEF; s_dat_i = 32'h12345678; s_ack_i = 1'b1;
        step();
        step();
        #1;
        checks++;
        if (st !== 8'h00 || s_adr_o !== '0 || s_dat_o !== '0 || m0_dat_o !== '0 || m1_dat_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: st=%b adr=%h dat=%h m0d=%h m1d=%h, want all 0",
                     st, s_adr_o, s_dat_o, m0_dat_o, m1_dat_o);
        end
        clear_inputs();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 24'h123456; m0_sel_i = 4'hF;
        #1;
        checks++;
        if (st !== 8'b00_00_0000) begin
            errors++; $display("FAIL read_request_cycle: st=%b want 00000000", st);
        end
        step();
        #1;
        checks++;
        if (st !== 8'b01_11_0000 || s_adr_o !== 24'h123456 || s_sel_o !== 4'hF) begin
            errors++; $display("FAIL read_grant: st=%b adr=%h sel=%h want 01110000 123456 f", st, s_adr_o, s_sel_o);
        end
        step();
        step();
        s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
        #1;
        checks++;
        if (st !== 8'b01_11_1000 || m0_dat_o !== 32'hDEADBEEF || m1_dat_o !== '0) begin
            errors++; $display("FAIL read_ack: st=%b m0d=%h m1d=%h want 01111000 deadbeef 0", st, m0_dat_o, m1_dat_o);
        end
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        checks++;
        if (st !== 8'b01_00_0000) begin
            errors++; $display("FAIL read_release: st=%b want 01000000", st);
        end
        step();
        s_dat_i = '0;
    endtask

    task automatic test_tie();
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 24'h000010;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 24'h000020;
        step();
        s_ack_i = 1'b1;
        #1;
        checks++;
        if (st !== 8'b01_11_1000 || s_adr_o !== 24'h000010) begin
            errors++; $display("FAIL tie_first_m0: st=%b adr=%h want 01111000 000010", st, s_adr_o);
        end
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        #1;
        checks++;
        if (st !== 8'b00_00_0000) begin
            errors++; $display("FAIL tie_idle_gap: st=%b want 00000000", st);
        end
        step();
        #1;
        checks++;
        if (st !== 8'b10_11_0000 || s_adr_o !== 24'h000020) begin
            errors++; $display("FAIL tie_then_m1: st=%b adr=%h want 10110000 000020", st, s_adr_o);
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        #1;
        checks++;
        if (gnt_o !== 2'b01) begin
            errors++; $display("FAIL tie_second_m0: gnt=%b want 01", gnt_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_burst();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 24'h000100; m1_sel_i = 4'hF;
        step();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 24'h000300;
        for (int k = 0; k < 4; k++) begin
            m1_adr_i = 24'h000100 + 24'(4 * k);
            m1_dat_i = 32'hA0000000 + 32'(k);
            s_ack_i  = 1'b1;
            #1;
            checks++;
            if (st !== 8'b10_11_0010 || s_adr_o !== m1_adr_i || s_dat_o !== m1_dat_i || s_we_o !== 1'b1) begin
                errors++;
                $display("FAIL burst_beat%0d: st=%b adr=%h dat=%h we=%b want 10110010 %h %h 1",
                         k, st, s_adr_o, s_dat_o, s_we_o, m1_adr_i, m1_dat_i);
            end
            step();
        end
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        #1;
        checks++;
        if (st !== 8'b10_00_0000) begin
            errors++; $display("FAIL burst_release: st=%b want 10000000", st);
        end
        step();
        #1;
        checks++;
        if (st !== 8'b00_00_0000) begin
            errors++; $display("FAIL burst_idle_gap: st=%b want 00000000", st);
        end
        step();
        #1;
        checks++;
        if (st !== 8'b01_11_0000 || s_adr_o !== 24'h000300) begin
            errors++; $display("FAIL burst_handover_m0: st=%b adr=%h want 01110000 000300", st, s_adr_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 24'h0000F0;
        step();
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (st !== 8'b01_11_0000) begin
                errors++; $display("FAIL timeout_wait%0d: st=%b want 01110000", i, st);
            end
            step();
        end
        #1;
        checks++;
        if (st !== 8'b01_10_0100) begin
            errors++; $display("FAIL timeout_err: st=%b want 01100100", st);
        end
        step();
        #1;
        checks++;
        if (st !== 8'b01_11_0000) begin
            errors++; $display("FAIL timeout_err_width: st=%b want 01110000", st);
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        #1;
        checks++;
        if (st !== 8'b00_00_0000) begin
            errors++; $display("FAIL timeout_to_idle: st=%b want 00000000", st);
        end
    endtask

    task automatic test_ack_at_timeout();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        repeat (8) step();
        s_ack_i = 1'b1; s_dat_i = 32'hCAFEF00D;
        #1;
        checks++;
        if (st !== 8'b01_11_1000 || m0_dat_o !== 32'hCAFEF00D) begin
            errors++; $display("FAIL ack_at_deadline: st=%b m0d=%h want 01111000 cafef00d", st, m0_dat_o);
        end
        step();
        s_ack_i = 1'b0;
        repeat (7) step();
        #1;
        checks++;
        if (st !== 8'b01_11_0000) begin
            errors++; $display("FAIL ack_restarts_wdog: st=%b want 01110000", st);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_async_reset();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 24'h000500; m1_dat_i = 32'h55AA55AA; m1_sel_i = 4'h3;
        step();
        s_ack_i = 1'b1; s_dat_i = 32'h0BADF00D;
        #1;
        checks++;
        if (st !== 8'b10_11_0010 || m1_dat_o !== 32'h0BADF00D) begin
            errors++; $display("FAIL arst_pre_own1: st=%b m1d=%h want 10110010 0badf00d", st, m1_dat_o);
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (st !== 8'h00 || s_adr_o !== '0 || s_dat_o !== '0 || s_sel_o !== '0 || s_we_o !== 1'b0
            || m1_dat_o !== '0) begin
            errors++;
            $display("FAIL arst_outputs: st=%b adr=%h dat=%h sel=%h we=%b m1d=%h want all 0",
                     st, s_adr_o, s_dat_o, s_sel_o, s_we_o, m1_dat_o);
        end
        clear_inputs();
        step();
        rstn = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        #1;
        checks++;
        if (st !== 8'b00_00_0000) begin
            errors++; $display("FAIL arst_idle: st=%b want 00000000", st);
        end
        step();
        #1;
        checks++;
        if (gnt_o !== 2'b01) begin
            errors++; $display("FAIL arst_tie_m0: gnt=%b want 01", gnt_o);
        end
        clear_inputs();
        step();
    endtask

    initial begin
        rstn = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_tie();
        test_burst();
        test_timeout();
        test_ack_at_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arb2.md
Name: wb_arb2

Overview:
- Two-master, one-slave Wishbone arbiter that shares the SoC peripheral bus between the RISC-V CPU data port (master 0) and the SPI-slave debug bridge (master 1).
- Uses round-robin arbitration with a grant lock for the whole `cyc` duration.
- Includes a per-cycle bus watchdog that terminates stalled transfers with `err`, so neither master can hang the bus.
- Sits between both masters and the address decoder / interconnect.

Parameters:
- AW, 24, address width; matches the 24-bit bridge address.
- DW, 32, data width.
- TIMEOUT, 255, cycles a strobe may wait for `ack` before `err` is issued; 0 disables the watchdog.
- CW, 8, watchdog counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- m0_adr_i  in  AW  master 0 address
- m0_dat_i  in  DW  master 0 write data
- m0_dat_o  out  DW  master 0 read data
- m0_sel_i  in  DW/8  master 0 byte selects
- m0_we_i / m0_cyc_i / m0_stb_i  in  1 each  master 0 control
- m0_ack_o / m0_err_o  out  1 each  master 0 termination
- m1_*  same set as m0_*, for master 1
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_dat_i  in  DW  slave read data
- s_sel_o  out  DW/8  slave byte selects
- s_we_o / s_cyc_o / s_stb_o  out  1 each  slave control
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  2  one-hot current owner (debug/observability)

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, last=1 (master 0 wins the first tie), wdog=0.
  - All outputs 0: s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, gnt_o, and every m*_ack_o, m*_err_o, m*_dat_o.
- States: IDLE, OWN0, OWN1 (registered).
- IDLE:
  - s_cyc_o=s_stb_o=0; gnt_o=00.
  - Only m0_cyc_i → OWN0. Only m1_cyc_i → OWN1.
  - Both → the master != last. Neither → stay.
- OWNn:
  - gnt_o one-hot n.
  - s_adr/dat/sel/we/cyc/stb driven combinationally from master n.
  - mn_ack_o = s_ack_i. mn_dat_o = s_dat_i.
  - The other master sees ack=err=0 and dat=0.
  - Stay while mn_cyc_i=1.
  - mn_cyc_i=0 → IDLE, last<=n. s_cyc_o drops in that same cycle.
- Handover cost: one IDLE cycle between owners, always. A requester waiting for the bus incurs 2 cycles minimum from the owner's cyc drop to its s_cyc_o.
- Ownership is never pre-empted. A master holding cyc across multiple strobes (bursts, read-modify-write) keeps the bus.
- Watchdog:
  - wdog clears on entry to OWNn, on any cycle with s_ack_i=1, and whenever mn_stb_i=0.
  - Otherwise it increments while mn_stb_i=1.
  - When wdog==TIMEOUT and s_ack_i=0:
    - mn_err_o=1 for exactly that cycle;
    - s_stb_o forced 0 that cycle;
    - wdog clears.
  - s_ack_i and timeout in the same cycle → ack wins, no err.
  - Master is expected to drop stb/cyc after err. If it keeps stb high, the watchdog restarts and re-fires every TIMEOUT+1 cycles.
- Master dropping cyc mid-transfer (e.g. bridge reset on SPI abort): the arbiter releases immediately as above. A late s_ack_i in IDLE is discarded (no ack to any master).
- Width rules: wdog saturates at TIMEOUT, never wraps. TIMEOUT=0 → wdog held 0 and err never asserted.
- s_ack_i is never routed while in IDLE. The slave must not ack without s_stb_o.

Test Plan:
- Reset, then m0_cyc/stb single read, slave acks after 3 cycles with 0xDEADBEEF:
  - gnt_o=01 one cycle after request;
  - m0_ack_o pulses with m0_dat_o=0xDEADBEEF;
  - m1 outputs stay 0.
- m0 and m1 both request in the same cycle after reset → OWN0 first; m0 drops cyc → one IDLE cycle → OWN1; next tie → OWN0.
- m1 holds cyc for a 4-strobe burst (addr 0x000100..0x00010C) while m0 requests → m0 waits until m1 cyc drops; m0 sees no ack or err during the burst.
- TIMEOUT=8, m0 strobes and the slave never acks:
  - m0_err_o=1 exactly 8 cycles after stb, one cycle wide, with s_stb_o=0 that cycle;
  - m0 drops cyc → IDLE.
- s_ack_i asserted on the exact cycle wdog==TIMEOUT → ack delivered, err=0.
- rstn asserted low mid-transfer in OWN1 → all outputs 0 asynchronously; after release, state=IDLE and a tie grants m0.
